// File: rtl/clock_div_controller_pkg.sv
// clock_div_controller_pkg: shared state encoding and default sizing for the slow-clock divider.
package clock_div_controller_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } ctrlState_t;
    localparam int DEF_CNT_W  = 13;
    localparam int DEF_LIMIT  = 8000;
    localparam int DEF_TCNT_W = 16;
endpackage

// File: rtl/clock_div_controller_div_counter.sv
// clock_div_controller_div_counter: divide counter with >= compare, registered outClk toggle and tick.
module clock_div_controller_div_counter
    import clock_div_controller_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             inClk,
    input  logic             nReset,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             outClk,
    output logic             tick,
    output logic             wrapNow
);
    logic [CNT_W-1:0] count;

    // >= so a limit shrunk below the running count ends the half-period at once
    assign wrapNow = en && !clr && (count >= limit);

    always_ff @(posedge inClk) begin
        if (!nReset || clr) begin
            count  <= '0;
            outClk <= 1'b0;
            tick   <= 1'b0;
        end else begin
            tick <= wrapNow;
            if (en) count <= wrapNow ? '0 : count + 1'b1;
            if (wrapNow) outClk <= !outClk;
        end
    end
endmodule

// File: rtl/clock_div_controller.sv
// clock_div_controller: run/pause/stop sequencer and limit reconfiguration front-end
// for the programmable slow-clock divider.
module clock_div_controller
    import clock_div_controller_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int DEFAULT_LIMIT = DEF_LIMIT,
    parameter int TCNT_W        = DEF_TCNT_W
) (
    input  logic              inClk,
    input  logic              nReset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              cfgValid,
    input  logic [CNT_W-1:0]  cfgLimit,
    output logic              cfgReady,
    output logic              outClk,
    output logic              tick,
    output logic              busy,
    output logic [TCNT_W-1:0] tickCount
);
    ctrlState_t state, nextState;
    logic [CNT_W-1:0] activeLimit, pendLimit;
    logic pendValid, cntEn, cntClr, wrapNow, apply;

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE:  nextState = (start && !stop) ? ST_RUN : ST_IDLE;
            ST_RUN:   nextState = stop ? ST_IDLE : (pause ? ST_PAUSE : ST_RUN);
            ST_PAUSE: nextState = stop ? ST_IDLE : (pause ? ST_PAUSE : ST_RUN);
            default:  nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge inClk) begin
        if (!nReset) state <= ST_IDLE;
        else state <= nextState;
    end

    assign cntEn    = (state == ST_RUN) && !stop && !pause;
    assign cntClr   = stop || (state == ST_IDLE);
    // while running, a new limit only lands on a toggle so the current half-period is untouched
    assign apply    = pendValid && ((state != ST_RUN) || wrapNow);
    assign cfgReady = !pendValid;
    assign busy     = state != ST_IDLE;

    always_ff @(posedge inClk) begin
        if (!nReset) begin
            activeLimit <= CNT_W'(DEFAULT_LIMIT);
            pendLimit   <= '0;
            pendValid   <= 1'b0;
        end else if (cfgValid && !pendValid) begin
            pendLimit <= cfgLimit;
            pendValid <= 1'b1;
        end else if (apply) begin
            activeLimit <= pendLimit;
            pendValid   <= 1'b0;
        end
    end

    always_ff @(posedge inClk) begin
        if (!nReset) tickCount <= '0;
        else if ((state == ST_IDLE) && start && !stop) tickCount <= '0;
        else if (wrapNow) tickCount <= tickCount + 1'b1;
    end

    clock_div_controller_div_counter #(.CNT_W(CNT_W)) divCounter (
        .inClk  (inClk),
        .nReset (nReset),
        .en     (cntEn),
        .clr    (cntClr),
        .limit  (activeLimit),
        .outClk (outClk),
        .tick   (tick),
        .wrapNow(wrapNow)
    );
endmodule

// File: tb/tb_clock_div_controller.sv
// tb_clock_div_controller: directed checks of the divider controller with DEFAULT_LIMIT=3, TCNT_W=4.
module tb_clock_div_controller;
    logic        inClk = 1'b0;
    logic        nReset, start, stop, pause, cfgValid;
    logic [12:0] cfgLimit;
    logic        cfgReady, outClk, tick, busy;
    logic [3:0]  tickCount;
    int testCount = 0;
    int failCount = 0;

    clock_div_controller #(.CNT_W(13), .DEFAULT_LIMIT(3), .TCNT_W(4)) dut (
        .inClk    (inClk),
        .nReset   (nReset),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .cfgValid (cfgValid),
        .cfgLimit (cfgLimit),
        .cfgReady (cfgReady),
        .outClk   (outClk),
        .tick     (tick),
        .busy     (busy),
        .tickCount(tickCount)
    );

    always #5 inClk = ~inClk;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge inClk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        testCount++;
        assert (obs === expv) else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chkOut(input string tag, input logic expClk, input logic expTick,
                          input logic expBusy, input logic [3:0] expCnt, input logic expReady);
        chk({tag, ".outClk"}, 32'(outClk), 32'(expClk));
        chk({tag, ".tick"}, 32'(tick), 32'(expTick));
        chk({tag, ".busy"}, 32'(busy), 32'(expBusy));
        chk({tag, ".tickCount"}, 32'(tickCount), 32'(expCnt));
        chk({tag, ".cfgReady"}, 32'(cfgReady), 32'(expReady));
    endtask

    initial begin
        nReset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        cfgValid = 1'b0; cfgLimit = '0;
        step();
        chkOut("reset", 0, 0, 0, 0, 1);
        nReset = 1'b1;
        // 1: start, outClk rises 4 cycles after RUN entry, then every 4
        start = 1'b1; step(); start = 1'b0;
        chkOut("runEntry", 0, 0, 1, 0, 1);
        step(3);
        chkOut("preEdge1", 0, 0, 1, 0, 1);
        step();
        chkOut("edge1", 1, 1, 1, 1, 1);
        step();
        chkOut("afterEdge1", 1, 0, 1, 1, 1);
        step(3);
        chkOut("edge2", 0, 1, 1, 2, 1);
        step(4);
        chkOut("edge3", 1, 1, 1, 3, 1);
        // 2: pause mid-half-period (counter=2)
        step(2);
        pause = 1'b1; step(10);
        chkOut("paused", 1, 0, 1, 3, 1);
        pause = 1'b0; step(2);
        chkOut("resumeNoEdge", 1, 0, 1, 3, 1);
        step();
        chkOut("resumeEdge", 0, 1, 1, 4, 1);
        // 3: offer limit 1 at counter=1
        step();
        cfgValid = 1'b1; cfgLimit = 13'd1; step(); cfgValid = 1'b0;
        chkOut("cfgAccepted", 0, 0, 1, 4, 0);
        step();
        chkOut("oldHalfPeriod", 0, 0, 1, 4, 0);
        step();
        chkOut("applyEdge", 1, 1, 1, 5, 1);
        step();
        chkOut("short1", 1, 0, 1, 5, 1);
        step();
        chkOut("short2", 0, 1, 1, 6, 1);
        step(2);
        chkOut("short3", 1, 1, 1, 7, 1);
        // 4: second offer while pending is held off until apply
        cfgValid = 1'b1; cfgLimit = 13'd2; step();
        cfgLimit = 13'd0;
        chkOut("pend2", 1, 0, 1, 7, 0);
        step();
        chkOut("apply2", 0, 1, 1, 8, 1);
        step(); cfgValid = 1'b0;
        chkOut("accept0", 0, 0, 1, 8, 0);
        step();
        chkOut("limit2mid", 0, 0, 1, 8, 0);
        step();
        chkOut("apply0", 1, 1, 1, 9, 1);
        step();
        chkOut("limit0a", 0, 1, 1, 10, 1);
        step();
        chkOut("limit0b", 1, 1, 1, 11, 1);
        // 5: stop+start on a toggle cycle
        stop = 1'b1; start = 1'b1; step(); stop = 1'b0; start = 1'b0;
        chkOut("stopOnToggle", 0, 0, 0, 11, 1);
        step();
        chkOut("idleHold", 0, 0, 0, 11, 1);
        start = 1'b1; step(); start = 1'b0;
        chkOut("restart", 0, 0, 1, 0, 1);
        step();
        chkOut("restartEdge", 1, 1, 1, 1, 1);
        // 6: reset mid-RUN with a pending limit
        cfgValid = 1'b1; cfgLimit = 13'd5; step(); cfgValid = 1'b0;
        chkOut("pendBeforeReset", 0, 1, 1, 2, 0);
        nReset = 1'b0; step(); nReset = 1'b1;
        chkOut("midRunReset", 0, 0, 0, 0, 1);
        start = 1'b1; step(); start = 1'b0;
        step(3);
        chkOut("defaultLimitPre", 0, 0, 1, 0, 1);
        step();
        chkOut("defaultLimitEdge", 1, 1, 1, 1, 1);
        // 7: 16 toggles wrap the 4-bit tickCount
        step(60);
        chkOut("wrap", 0, 1, 1, 0, 1);
        // stop on a non-toggle cycle keeps tickCount
        step();
        stop = 1'b1; step(); stop = 1'b0;
        chkOut("stopMid", 0, 0, 0, 0, 1);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
